// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared board geometry, piece/rotation encodings, the
//                board_keeper state enum and the piece_mask() helper that
//                maps (type, anchor, rotation) to a 32-bit cell mask.
//                Cell index = row*4 + col; row 0 is the top of the board.
//  Revision    : 1.0  initial release
// ============================================================================
package tetris_pkg;

    localparam int          COLS      = 4;
    localparam int          ROWS      = 8;
    localparam int          BOARD_W   = 32;
    localparam logic [4:0]  SPAWN_LOC = 5'd5;

    typedef enum logic [1:0] {
        PIECE_DOT    = 2'b00,
        PIECE_BAR2   = 2'b01,
        PIECE_SQUARE = 2'b10,
        PIECE_ELL    = 2'b11
    } piece_t;

    typedef enum logic [1:0] {
        ROT_0   = 2'b00,
        ROT_90  = 2'b01,
        ROT_180 = 2'b10,
        ROT_270 = 2'b11
    } rot_t;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_SCAN  = 2'b01,
        ST_SPAWN = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    // Every piece is a prefix of the cell list (0,0) (-1,0) (0,+1) (-1,+1)
    // given as (row, col) offsets from the anchor: dot takes 1 cell, bar 2,
    // ell 3, square 4. Each rotation step maps (dr, dc) -> (dc, -dr).
    // Cells that fall off the board are dropped.
    function automatic logic [BOARD_W-1:0] piece_mask(
        input logic [1:0] ptype,
        input logic [4:0] loc,
        input logic [1:0] rot
    );
        logic [BOARD_W-1:0] m;
        int n;
        int r;
        int c;
        int t;
        int rr;
        int cc;
        m = '0;
        case (ptype)
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b11:   n = 3;
            default: n = 4;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                r = -(i % 2);
                c = i / 2;
                for (int k = 0; k < 3; k++) begin
                    if (k < int'(rot)) begin
                        t = r;
                        r = c;
                        c = -t;
                    end
                end
                rr = int'(loc[4:2]) + r;
                cc = int'(loc[1:0]) + c;
                if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                    m = m | (BOARD_W'(1) << (rr * COLS + cc));
                end
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : piece_lfsr
//  Description : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running
//                (advances on every clock edge out of reset).
//  Ports       : clka       in   clock
//                restart_n  in   asynchronous active-low reset
//                lfsr_state out  8-bit current state
//  Revision    : 1.0  initial release
// ============================================================================
module piece_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clka,
    input  logic       restart_n,
    output logic [7:0] lfsr_state
);

    // An all-zero state would lock up the LFSR.
    localparam logic [7:0] C_RESET_VAL = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            lfsr_q <= C_RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_state = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/board_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : board_keeper
//  Description : Registers move_piece results back into the curr_* game
//                state. On lock it scans rows bottom-up clearing full rows,
//                counts them, then spawns the next pseudo-random piece.
//  Ports       : clka, restart_n (async active-low)
//                step_valid, new_board_state, new_location, new_rotation,
//                touched                         - from move_piece
//                curr_board_state, curr_piece_location, curr_piece_rotation,
//                curr_piece_type                 - to move_piece
//                busy, lines_cleared, game_over  - status
//  Revision    : 1.0  initial release
// ============================================================================
module board_keeper
    import tetris_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         SCORE_W   = 8
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               step_valid,
    input  logic [31:0]        new_board_state,
    input  logic [4:0]         new_location,
    input  logic [1:0]         new_rotation,
    input  logic               touched,
    output logic [31:0]        curr_board_state,
    output logic [4:0]         curr_piece_location,
    output logic [1:0]         curr_piece_rotation,
    output logic [1:0]         curr_piece_type,
    output logic               busy,
    output logic [SCORE_W-1:0] lines_cleared,
    output logic               game_over
);

    logic [7:0] lfsr_state;
    logic       lfsr_unused_bits;

    piece_lfsr #(
        .SEED       (LFSR_SEED)
    ) u_piece_lfsr (
        .clka       (clka),
        .restart_n  (restart_n),
        .lfsr_state (lfsr_state)
    );

    // Only the two low bits select the piece type.
    assign lfsr_unused_bits = &{1'b0, lfsr_state[7:2]};

    state_t               state_q,  state_d;
    logic [BOARD_W-1:0]   board_q,  board_d;
    logic [4:0]           loc_q,    loc_d;
    logic [1:0]           rot_q,    rot_d;
    logic [1:0]           type_q,   type_d;
    logic [2:0]           row_q,    row_d;
    logic [SCORE_W-1:0]   lines_q,  lines_d;
    logic                 over_q,   over_d;
    logic                 busy_q,   busy_d;

    logic                 row_full;
    logic [BOARD_W-1:0]   cleared_board;
    logic [BOARD_W-1:0]   spawn_mask;

    assign row_full   = &board_q[{row_q, 2'b00} +: 4];
    assign spawn_mask = piece_mask(lfsr_state[1:0], SPAWN_LOC, 2'b00);

    // Drop row row_q: rows above it slide down one, row 0 becomes empty,
    // rows below it are untouched.
    always_comb begin
        cleared_board = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (i > int'(row_q)) begin
                cleared_board[i*COLS +: COLS] = board_q[i*COLS +: COLS];
            end else if (i > 0) begin
                cleared_board[i*COLS +: COLS] = board_q[(i-1)*COLS +: COLS];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        loc_d   = loc_q;
        rot_d   = rot_q;
        type_d  = type_q;
        row_d   = row_q;
        lines_d = lines_q;
        over_d  = over_q;
        case (state_q)
            ST_PLAY: begin
                if (step_valid) begin
                    board_d = new_board_state;
                    loc_d   = new_location;
                    rot_d   = new_rotation;
                    if (touched) begin
                        state_d = ST_SCAN;
                        row_d   = 3'd7;
                    end
                end
            end
            ST_SCAN: begin
                if (row_full) begin
                    // Row pointer stays put: the row that slid in is rechecked.
                    board_d = cleared_board;
                    if (lines_q != {SCORE_W{1'b1}}) begin
                        lines_d = lines_q + 1'b1;
                    end
                end else if (row_q != 3'd0) begin
                    row_d = row_q - 3'd1;
                end else begin
                    state_d = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                if (|(board_q & spawn_mask)) begin
                    state_d = ST_OVER;
                    over_d  = 1'b1;
                end else begin
                    board_d = board_q | spawn_mask;
                    loc_d   = SPAWN_LOC;
                    rot_d   = 2'b00;
                    type_d  = lfsr_state[1:0];
                    state_d = ST_PLAY;
                end
            end
            default: begin
                // ST_OVER: everything holds until restart_n.
            end
        endcase
        busy_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q <= ST_SPAWN;
            board_q <= '0;
            loc_q   <= SPAWN_LOC;
            rot_q   <= 2'b00;
            type_q  <= 2'b00;
            row_q   <= 3'd7;
            lines_q <= '0;
            over_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            loc_q   <= loc_d;
            rot_q   <= rot_d;
            type_q  <= type_d;
            row_q   <= row_d;
            lines_q <= lines_d;
            over_q  <= over_d;
            busy_q  <= busy_d;
        end
    end

    assign curr_board_state    = board_q;
    assign curr_piece_location = loc_q;
    assign curr_piece_rotation = rot_q;
    assign curr_piece_type     = type_q;
    assign busy                = busy_q;
    assign lines_cleared       = lines_q;
    assign game_over           = over_q;

endmodule
`default_nettype wire

// File: tb/tb_board_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_keeper
//  Description : Directed bench for board_keeper. Lock requests push their
//                expected outcome into a queue; the entry is popped and
//                compared once busy drops after the spawn.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_keeper;

    logic        clka = 1'b0;
    logic        restart_n = 1'b0;
    logic        step_valid = 1'b0;
    logic [31:0] new_board_state = '0;
    logic [4:0]  new_location = '0;
    logic [1:0]  new_rotation = '0;
    logic        touched = 1'b0;
    logic [31:0] curr_board_state;
    logic [4:0]  curr_piece_location;
    logic [1:0]  curr_piece_rotation;
    logic [1:0]  curr_piece_type;
    logic        busy;
    logic [7:0]  lines_cleared;
    logic        game_over;

    board_keeper #(
        .LFSR_SEED (8'hA5),
        .SCORE_W   (8)
    ) dut (
        .clka                (clka),
        .restart_n           (restart_n),
        .step_valid          (step_valid),
        .new_board_state     (new_board_state),
        .new_location        (new_location),
        .new_rotation        (new_rotation),
        .touched             (touched),
        .curr_board_state    (curr_board_state),
        .curr_piece_location (curr_piece_location),
        .curr_piece_rotation (curr_piece_rotation),
        .curr_piece_type     (curr_piece_type),
        .busy                (busy),
        .lines_cleared       (lines_cleared),
        .game_over           (game_over)
    );

    always #5 clka = ~clka;

    int errors = 0;
    int checks = 0;

    // Reference LFSR; lfsr_prev is the value that was current before the
    // most recent edge, i.e. the one a spawn on that edge used.
    logic [7:0] lfsr_m;
    logic [7:0] lfsr_prev;
    always @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            lfsr_m    <= 8'hA5;
            lfsr_prev <= 8'hA5;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
    end

    typedef struct {
        logic [31:0] board_pre;   // board after clearing, before spawn
        int          k;           // rows cleared
        logic [7:0]  lines;
    } exp_t;

    exp_t sb[$];
    logic [7:0] lines_m = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] spawn_cells(input logic [1:0] t);
        case (t)
            2'b00:   return 32'h0000_0020;
            2'b01:   return 32'h0000_0022;
            2'b10:   return 32'h0000_0066;
            default: return 32'h0000_0062;
        endcase
    endfunction

    // Compact remaining rows toward the bottom, skipping full rows.
    task automatic clear_model(input logic [31:0] b, output logic [31:0] o, output int k);
        int w;
        logic [3:0] row;
        o = '0;
        k = 0;
        w = 7;
        for (int r = 7; r >= 0; r--) begin
            row = b[r*4 +: 4];
            if (row == 4'hF) begin
                k++;
            end else begin
                o[w*4 +: 4] = row;
                w--;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_board"}, curr_board_state, 32'h0);
        chk({tag, "_loc"},   {27'd0, curr_piece_location}, 32'd5);
        chk({tag, "_rot"},   {30'd0, curr_piece_rotation}, 32'd0);
        chk({tag, "_type"},  {30'd0, curr_piece_type}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
        chk({tag, "_lines"}, {24'd0, lines_cleared}, 32'd0);
        chk({tag, "_over"},  {31'd0, game_over}, 32'd0);
    endtask

    // Issue a locking step, wait for busy to drop, then pop and compare.
    task automatic lock_and_check(input string tag, input logic [31:0] b, input bit junk);
        exp_t e;
        exp_t got;
        logic [31:0] cl;
        int k;
        int n;
        logic [31:0] m;
        clear_model(b, cl, k);
        lines_m = ((32'(lines_m) + 32'(k)) > 255) ? 8'd255 : lines_m + 8'(k);
        e.board_pre = cl;
        e.k = k;
        e.lines = lines_m;
        @(negedge clka);
        step_valid = 1'b1;
        touched = 1'b1;
        new_board_state = b;
        new_location = 5'd13;
        new_rotation = 2'd2;
        sb.push_back(e);
        @(negedge clka);
        step_valid = 1'b0;
        touched = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            if (junk && n == 2) begin
                step_valid = 1'b1;
                touched = 1'b1;
                new_board_state = 32'hDEAD_BEEF;
                new_location = 5'd3;
                new_rotation = 2'd3;
            end
            @(negedge clka);
            step_valid = 1'b0;
            touched = 1'b0;
        end
        got = sb.pop_front();
        m = spawn_cells(lfsr_prev[1:0]);
        chk({tag, "_busy_cycles"}, n, 32'(9 + got.k));
        chk({tag, "_board"}, curr_board_state, got.board_pre | m);
        chk({tag, "_type"}, {30'd0, curr_piece_type}, {30'd0, lfsr_prev[1:0]});
        chk({tag, "_loc"}, {27'd0, curr_piece_location}, 32'd5);
        chk({tag, "_lines"}, {24'd0, lines_cleared}, {24'd0, got.lines});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, then the first spawn on the first released edge.
        repeat (3) @(negedge clka);
        check_reset_values("reset");
        restart_n = 1'b1;
        @(negedge clka);
        chk("spawn0_type",  {30'd0, curr_piece_type}, 32'd1);
        chk("spawn0_board", curr_board_state, 32'h0000_0022);
        chk("spawn0_loc",   {27'd0, curr_piece_location}, 32'd5);
        chk("spawn0_rot",   {30'd0, curr_piece_rotation}, 32'd0);
        chk("spawn0_busy",  {31'd0, busy}, 32'd0);

        // Plain move step: curr_* follow the inputs with no added latency.
        step_valid = 1'b1;
        touched = 1'b0;
        new_board_state = 32'h0000_0220;
        new_location = 5'd9;
        new_rotation = 2'd1;
        @(negedge clka);
        step_valid = 1'b0;
        chk("move_board", curr_board_state, 32'h0000_0220);
        chk("move_loc",   {27'd0, curr_piece_location}, 32'd9);
        chk("move_rot",   {30'd0, curr_piece_rotation}, 32'd1);
        chk("move_type",  {30'd0, curr_piece_type}, 32'd1);
        chk("move_busy",  {31'd0, busy}, 32'd0);
        @(negedge clka);
        chk("hold_board", curr_board_state, 32'h0000_0220);

        // Single-row clear, with a dropped step_valid during busy.
        lock_and_check("lock_f1", 32'hF100_0000, 1'b1);
        chk("lock_f1_bottom", {28'd0, curr_board_state[31:28]}, 32'h1);
        // Two simultaneous full rows.
        lock_and_check("lock_ff", 32'hFF00_0000, 1'b0);
        // No clears, arbitrary content.
        lock_and_check("lock_none", 32'h3000_0000, 1'b0);
        // Saturate the counter with whole-board clears.
        for (int i = 0; i < 32; i++) begin
            lock_and_check("lock_full", 32'hFFFF_FFFF, 1'b0);
        end
        lock_and_check("lock_sat", 32'hFF00_0000, 1'b1);
        chk("sat_lines", {24'd0, lines_cleared}, 32'd255);

        // Spawn collision: game over, board and curr_* frozen.
        begin
            logic [1:0] t_before;
            t_before = curr_piece_type;
            @(negedge clka);
            step_valid = 1'b1;
            touched = 1'b1;
            new_board_state = 32'h0000_0020;
            new_location = 5'd13;
            new_rotation = 2'd2;
            @(negedge clka);
            step_valid = 1'b0;
            touched = 1'b0;
            repeat (12) @(negedge clka);
            chk("over_flag",  {31'd0, game_over}, 32'd1);
            chk("over_busy",  {31'd0, busy}, 32'd1);
            chk("over_board", curr_board_state, 32'h0000_0020);
            chk("over_loc",   {27'd0, curr_piece_location}, 32'd13);
            chk("over_rot",   {30'd0, curr_piece_rotation}, 32'd2);
            chk("over_type",  {30'd0, curr_piece_type}, {30'd0, t_before});
            step_valid = 1'b1;
            new_board_state = 32'h1234_5678;
            new_location = 5'd1;
            new_rotation = 2'd1;
            @(negedge clka);
            step_valid = 1'b0;
            @(negedge clka);
            chk("over_ignore_board", curr_board_state, 32'h0000_0020);
            chk("over_ignore_loc",   {27'd0, curr_piece_location}, 32'd13);
            chk("over_sticky",       {31'd0, game_over}, 32'd1);
            chk("over_lines",        {24'd0, lines_cleared}, 32'd255);
        end

        // Restart out of OVER.
        restart_n = 1'b0;
        #1;
        check_reset_values("restart_over");
        @(negedge clka);
        restart_n = 1'b1;
        lines_m = 8'd0;
        @(negedge clka);
        chk("respawn_type",  {30'd0, curr_piece_type}, 32'd1);
        chk("respawn_board", curr_board_state, 32'h0000_0022);
        chk("respawn_busy",  {31'd0, busy}, 32'd0);

        // Restart on the 3rd SCAN cycle discards the partial clear.
        @(negedge clka);
        step_valid = 1'b1;
        touched = 1'b1;
        new_board_state = 32'hFF10_0000;
        new_location = 5'd9;
        new_rotation = 2'd0;
        @(negedge clka);
        step_valid = 1'b0;
        touched = 1'b0;
        chk("scan1_busy", {31'd0, busy}, 32'd1);
        @(negedge clka);
        @(negedge clka);
        restart_n = 1'b0;
        #1;
        check_reset_values("restart_scan");
        @(negedge clka);
        restart_n = 1'b1;
        @(negedge clka);
        chk("after_scan_restart_board", curr_board_state, 32'h0000_0022);
        chk("after_scan_restart_lines", {24'd0, lines_cleared}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
